// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default sizing for the register file
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_DEFAULT = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register, set on issue, cleared on writeback; bit 0 never set
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set,
  input  logic [AW-1:0] set_idx,
  input  logic          clr,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_idx_1,
  input  logic [AW-1:0] rd_idx_2,
  output logic          pend_1,
  output logic          pend_2
);
  logic [NREGS-1:0] bits;
  // set is applied after clear so a new producer supersedes the completing one
  always_ff @(posedge clock) begin
    if (reset) begin
      bits <= '0;
    end else begin
      if (clr) bits[clr_idx] <= 1'b0;
      if (set && set_idx != '0) bits[set_idx] <= 1'b1;
    end
  end
  assign pend_1 = bits[rd_idx_1];
  assign pend_2 = bits[rd_idx_2];
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with clear sweep, pending scoreboard and optional write bypass (REGFILE_BYPASS_EN)
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write_enable,
  input  logic [AW-1:0]   write_select,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data_1,
  output logic [XLEN-1:0] read_data_2,
  input  logic            pend_set,
  input  logic [AW-1:0]   pend_select,
  output logic            pend_1,
  output logic            pend_2,
  output logic            ready
);
  state_t state;
  logic [AW-1:0] sweep_cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic rdy, wr_fire, sb_1, sb_2, hit_1, hit_2;
  assign rdy = state == READY;
  assign ready = rdy;
  assign wr_fire = rdy && write_enable && write_select != '0;
  // sweep zeroes one register per cycle, then normal writeback is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      sweep_cnt <= '0;
    end else if (!rdy) begin
      regs[sweep_cnt] <= '0;
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == AW'(NREGS - 1)) state <= READY;
    end else if (wr_fire) begin
      regs[write_select] <= write_data;
    end
  end
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clock(clock),
    .reset(reset),
    .set(rdy && pend_set),
    .set_idx(pend_select),
    .clr(wr_fire),
    .clr_idx(write_select),
    .rd_idx_1(rs1),
    .rd_idx_2(rs2),
    .pend_1(sb_1),
    .pend_2(sb_2)
  );
`ifdef REGFILE_BYPASS_EN
  assign hit_1 = wr_fire && rs1 == write_select;
  assign hit_2 = wr_fire && rs2 == write_select;
`else
  assign hit_1 = 1'b0;
  assign hit_2 = 1'b0;
`endif
  assign read_data_1 = !rdy || rs1 == '0 ? '0 : hit_1 ? write_data : regs[rs1];
  assign read_data_2 = !rdy || rs2 == '0 ? '0 : hit_2 ? write_data : regs[rs2];
  assign pend_1 = rdy && (hit_1 ? pend_set && pend_select == rs1 : sb_1);
  assign pend_2 = rdy && (hit_2 ? pend_set && pend_select == rs2 : sb_2);
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized and directed checks of regfile_param against an array-based reference model
module tb_regfile_param;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int WX = 64;
  localparam int WN = 16;
  localparam int WA = 4;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, write_enable, pend_set, pend_1, pend_2, ready;
  logic [AW-1:0] write_select, rs1, rs2, pend_select;
  logic [XLEN-1:0] write_data, read_data_1, read_data_2;
  logic reset_w, write_enable_w, pend_set_w, pend_1_w, pend_2_w, ready_w;
  logic [WA-1:0] write_select_w, rs1_w, rs2_w, pend_select_w;
  logic [WX-1:0] write_data_w, read_data_1_w, read_data_2_w;
  regfile_param u_dut (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_select(write_select),
    .write_data(write_data), .rs1(rs1), .rs2(rs2), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .pend_set(pend_set), .pend_select(pend_select), .pend_1(pend_1), .pend_2(pend_2), .ready(ready)
  );
  regfile_param #(.XLEN(WX), .NREGS(WN)) u_dut_w (
    .clock(clock), .reset(reset_w), .write_enable(write_enable_w), .write_select(write_select_w),
    .write_data(write_data_w), .rs1(rs1_w), .rs2(rs2_w), .read_data_1(read_data_1_w), .read_data_2(read_data_2_w),
    .pend_set(pend_set_w), .pend_select(pend_select_w), .pend_1(pend_1_w), .pend_2(pend_2_w), .ready(ready_w)
  );
  logic [XLEN-1:0] m_regs [NREGS];
  bit m_pend [NREGS];
  int m_left;
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic hit(input logic [AW-1:0] rs);
`ifdef REGFILE_BYPASS_EN
    return write_enable && write_select != 0 && rs == write_select;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] rs);
    if (m_left != 0 || rs == 0) return '0;
    if (hit(rs)) return write_data;
    return m_regs[rs];
  endfunction
  function automatic logic exp_pend(input logic [AW-1:0] rs);
    if (m_left != 0) return 1'b0;
    if (hit(rs)) return pend_set && pend_select == rs;
    return m_pend[rs];
  endfunction
  task automatic model_edge();
    if (reset) begin
      m_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (write_enable && write_select != 0) begin
        m_regs[write_select] = write_data;
        m_pend[write_select] = 1'b0;
      end
      if (pend_set && pend_select != 0) m_pend[pend_select] = 1'b1;
    end
  endtask
  task automatic cycle();
    @(negedge clock);
    check("ready", {63'd0, ready}, {63'd0, m_left == 0});
    check("rd1", {32'd0, read_data_1}, {32'd0, exp_data(rs1)});
    check("rd2", {32'd0, read_data_2}, {32'd0, exp_data(rs2)});
    check("pend1", {63'd0, pend_1}, {63'd0, exp_pend(rs1)});
    check("pend2", {63'd0, pend_2}, {63'd0, exp_pend(rs2)});
    @(posedge clock);
    model_edge();
    #1;
  endtask
  task automatic idle();
    reset = 1'b0;
    write_enable = 1'b0;
    pend_set = 1'b0;
  endtask
  task automatic sweep(input string tag, input int exp_n);
    int n = 0;
    while (!ready && n < 200) begin
      cycle();
      n++;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask
  task automatic rand_inputs();
    write_enable = 1'($urandom_range(0, 1));
    write_select = AW'($urandom);
    write_data = $urandom;
    pend_set = 1'($urandom_range(0, 1));
    pend_select = $urandom_range(0, 3) == 0 ? write_select : AW'($urandom);
    rs1 = $urandom_range(0, 2) == 0 ? write_select : AW'($urandom);
    rs2 = $urandom_range(0, 3) == 0 ? rs1 : AW'($urandom);
    reset = $urandom_range(0, 299) == 0;
  endtask
  initial begin
    int n;
    reset = 1'b1;
    write_enable = 1'b0;
    pend_set = 1'b0;
    write_select = '0;
    write_data = '0;
    pend_select = '0;
    rs1 = 5;
    rs2 = 7;
    reset_w = 1'b1;
    write_enable_w = 1'b0;
    pend_set_w = 1'b0;
    write_select_w = '0;
    write_data_w = '0;
    pend_select_w = '0;
    rs1_w = '0;
    rs2_w = '0;
    @(posedge clock);
    model_edge();
    #1;
    cycle();
    idle();
    sweep("sweep_len", NREGS);
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i);
      rs2 = AW'(NREGS - 1 - i);
      cycle();
      check("cleared", {32'd0, read_data_1}, 64'd0);
    end
    write_enable = 1'b1;
    write_select = 5;
    write_data = 32'hDEADBEEF;
    cycle();
    idle();
    rs1 = 5;
    #1 check("x5_read", {32'd0, read_data_1}, 64'hDEADBEEF);
    write_enable = 1'b1;
    write_select = 0;
    write_data = 32'h1234;
    cycle();
    idle();
    rs2 = 0;
    #1 check("x0_read", {32'd0, read_data_2}, 64'd0);
    cycle();
    pend_set = 1'b1;
    pend_select = 7;
    rs1 = 7;
    cycle();
    idle();
    #1 check("pend_set", {63'd0, pend_1}, 64'd1);
    write_enable = 1'b1;
    write_select = 7;
    write_data = 32'h77;
    pend_set = 1'b1;
    pend_select = 7;
    cycle();
    idle();
    #1 check("pend_set_wins", {63'd0, pend_1}, 64'd1);
    write_enable = 1'b1;
    write_select = 7;
    write_data = 32'h78;
    cycle();
    idle();
    #1 check("pend_clr", {63'd0, pend_1}, 64'd0);
    write_enable = 1'b1;
    write_select = 3;
    write_data = 32'h1;
    cycle();
    write_data = 32'hA5A5A5A5;
    rs1 = 3;
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass_rd1", {32'd0, read_data_1}, 64'hA5A5A5A5);
`else
    #1 check("bypass_rd1", {32'd0, read_data_1}, 64'h1);
`endif
    cycle();
    idle();
    #1 check("x3_after", {32'd0, read_data_1}, 64'hA5A5A5A5);
    write_enable = 1'b1;
    write_select = 9;
    write_data = 32'hCAFE;
    reset = 1'b1;
    cycle();
    idle();
    sweep("sweep_after_ready_reset", NREGS);
    rs1 = 9;
    #1 check("reset_drops_write", {32'd0, read_data_1}, 64'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sweep("sweep_restart", NREGS);
    repeat (3000) begin
      rand_inputs();
      cycle();
    end
    idle();
    sweep("sweep_final", m_left);
    reset_w = 1'b0;
    n = 0;
    while (!ready_w && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
    check("w_sweep_len", 64'(n), 64'(WN));
    write_enable_w = 1'b1;
    write_select_w = 15;
    write_data_w = 64'hFFFF_0000_FFFF_0000;
    @(posedge clock);
    #1 write_enable_w = 1'b0;
    rs1_w = 15;
    rs2_w = 15;
    #1 check("w_x15_rd1", read_data_1_w, 64'hFFFF_0000_FFFF_0000);
    check("w_x15_rd2", read_data_2_w, 64'hFFFF_0000_FFFF_0000);
    check("w_x15_pend", {62'd0, pend_1_w, pend_2_w}, 64'd0);
    rs1_w = 0;
    #1 check("w_x0_read", read_data_1_w, 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
